// File: rtl/noc_arb_pkg.sv
// Shared definitions for the NoC router output-port arbiters:
// direction codes, default address width and the arbiter state type.
package noc_arb_pkg;

   // Next-hop direction codes carried with each head flit
   localparam int DIR_N = 0;
   localparam int DIR_S = 1;
   localparam int DIR_W = 2;
   localparam int DIR_E = 3;
   localparam int DIR_L = 4;

   // Default width of a next-hop direction code
   localparam int NOC_ADDR_W = 3;

   // Per-port arbitration state: free, or locked to one wormhole packet
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

endpackage : noc_arb_pkg

// File: rtl/rr_pick_from_ptr.sv
// Rotating-priority picker: returns the first set desire bit found when
// scanning from ptr upward with wrap at NUM_REQ. Purely combinational,
// built as a double-width rotate followed by a lowest-bit priority encoder.
module rr_pick_from_ptr #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] desire,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] pick,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [IDX_W-1:0]     off;
   logic [IDX_W:0]       sum;

   // Rotate so that bit 0 is the requester at ptr, encode, then rotate back
   always_comb begin
      // NOTE: every variable gets a default before any conditional update so no latch is inferred.
      off = '0;
      pick = '0;
      dbl = {desire, desire};
      rot = dbl[ptr +: NUM_REQ];
      any = |desire;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) off = IDX_W'(k);
      end
      // Wrap at NUM_REQ, not 2^IDX_W, so non-power-of-two sizes stay in range
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
      if (any) pick[idx] = 1'b1;
   end

endmodule : rr_pick_from_ptr

// File: rtl/noc_rr_port_arbiter.sv
// Round-robin arbiter for one router output port. Decodes each requester's
// next-hop code against PORT_ID, grants in rotating-priority order and holds
// the grant until the packet tail is released.
// Optional feature macro: NOC_ARB_HOLD_TIMEOUT_EN (forced release after a
// bounded hold time, with a hold_timeout_o pulse).
module noc_rr_port_arbiter
   import noc_arb_pkg::*;
#(
   parameter int                              NUM_REQ = 4,
   parameter int                              ADDR_W  = NOC_ADDR_W,
   parameter logic [ADDR_W-1:0]               PORT_ID = ADDR_W'(DIR_N),
   localparam int                             IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ*ADDR_W-1:0] req_nexthop_addr_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic                      release_i,
   output logic [NUM_REQ-1:0]        grant_o,
   output logic                      grant_valid_o,
   output logic [IDX_W-1:0]          grant_idx_o,
`ifdef NOC_ARB_HOLD_TIMEOUT_EN
   output logic                      hold_timeout_o,
`endif
   output logic [IDX_W-1:0]          rr_ptr_o
);

   arb_state_t           state;
   logic [NUM_REQ-1:0]   desire;
   logic [NUM_REQ-1:0]   pick;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_any;
   logic [IDX_W-1:0]     ptr_adv;
   logic [IDX_W-1:0]     ptr_sel;
   logic                 rel;

`ifdef NOC_ARB_HOLD_TIMEOUT_EN
   localparam int MAX_HOLD = 16;
   localparam int HOLD_W   = $clog2(MAX_HOLD);
   logic [HOLD_W-1:0] hold_cnt;
   logic              timeout_hit;
`endif

   // A requester wants this port when it is valid and its next hop matches
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         desire[i] = req_valid_i[i] && (req_nexthop_addr_i[i*ADDR_W +: ADDR_W] == PORT_ID);
      end
   end

   // Release condition, pointer successor and the pointer used for this edge's pick
   always_comb begin
`ifdef NOC_ARB_HOLD_TIMEOUT_EN
      timeout_hit = (hold_cnt == HOLD_W'(MAX_HOLD - 1)) && !release_i;
      rel = release_i || timeout_hit;
`else
      rel = release_i;
`endif
      ptr_adv = (grant_idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_o + 1'b1;
      // On a release the re-arbitration already uses the advanced pointer
      ptr_sel = (state == BUSY && rel) ? ptr_adv : rr_ptr_o;
   end

   rr_pick_from_ptr #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .desire (desire),
      .ptr    (ptr_sel),
      .pick   (pick),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // Grant FSM: lock on a pick in IDLE, hold in BUSY until release, hand off without a bubble
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state         <= IDLE;
         grant_o       <= '0;
         grant_valid_o <= 1'b0;
         grant_idx_o   <= '0;
         rr_ptr_o      <= '0;
`ifdef NOC_ARB_HOLD_TIMEOUT_EN
         hold_cnt       <= '0;
         hold_timeout_o <= 1'b0;
`endif
      end else begin
`ifdef NOC_ARB_HOLD_TIMEOUT_EN
         hold_timeout_o <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (pick_any) begin
                  state         <= BUSY;
                  grant_o       <= pick;
                  grant_valid_o <= 1'b1;
                  grant_idx_o   <= pick_idx;
`ifdef NOC_ARB_HOLD_TIMEOUT_EN
                  hold_cnt      <= '0;
`endif
               end
            end
            BUSY: begin
               if (rel) begin
                  rr_ptr_o <= ptr_adv;
`ifdef NOC_ARB_HOLD_TIMEOUT_EN
                  hold_cnt       <= '0;
                  hold_timeout_o <= timeout_hit;
`endif
                  if (pick_any) begin
                     grant_o       <= pick;
                     grant_valid_o <= 1'b1;
                     grant_idx_o   <= pick_idx;
                  end else begin
                     state         <= IDLE;
                     grant_o       <= '0;
                     grant_valid_o <= 1'b0;
                     grant_idx_o   <= '0;
                  end
               end else begin
`ifdef NOC_ARB_HOLD_TIMEOUT_EN
                  hold_cnt <= hold_cnt + 1'b1;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule : noc_rr_port_arbiter

// File: tb/tb_noc_rr_port_arbiter.sv
// Self-checking bench for noc_rr_port_arbiter (NUM_REQ=4, PORT_ID=0).
// A rule-level model tracks the expected grant and pointer; a negedge
// process compares every cycle, and directed steps pin literal values.
module tb_noc_rr_port_arbiter;

   localparam int N  = 4;
   localparam int AW = 3;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [N*AW-1:0] addr;
   logic [N-1:0]    valid;
   logic            release_in;
   logic [N-1:0]    grant;
   logic            grant_valid;
   logic [IW-1:0]   grant_idx;
   logic [IW-1:0]   rr_ptr;
`ifdef NOC_ARB_HOLD_TIMEOUT_EN
   logic            hold_timeout;
`endif

   int checks = 0;
   int errors = 0;

   // Model state
   int m_gnt = -1;
   int m_ptr = 0;
   bit m_ok  = 1'b0;
`ifdef NOC_ARB_HOLD_TIMEOUT_EN
   int m_cnt = 0;
   bit m_to  = 1'b0;
`endif

   always #5 clk = ~clk;

   noc_rr_port_arbiter #(
      .NUM_REQ (N),
      .ADDR_W  (AW),
      .PORT_ID (3'd0)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .req_nexthop_addr_i (addr),
      .req_valid_i        (valid),
      .release_i          (release_in),
      .grant_o            (grant),
      .grant_valid_o      (grant_valid),
      .grant_idx_o        (grant_idx),
`ifdef NOC_ARB_HOLD_TIMEOUT_EN
      .hold_timeout_o     (hold_timeout),
`endif
      .rr_ptr_o           (rr_ptr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit wants(int j);
      return valid[j] && (addr[j*AW +: AW] == 3'd0);
   endfunction

   // First desiring requester scanning p, p+1, ... modulo N; -1 when none
   function automatic int first_from(int p);
      for (int k = 0; k < N; k++) begin
         if (wants((p + k) % N)) return (p + k) % N;
      end
      return -1;
   endfunction

   // Model: apply the arbitration rules at each rising edge
   always @(posedge clk) begin
      bit rel;
      rel = release_in;
`ifdef NOC_ARB_HOLD_TIMEOUT_EN
      m_to = 1'b0;
      if (!reset && m_gnt >= 0 && !release_in && m_cnt == 15) begin
         rel  = 1'b1;
         m_to = 1'b1;
      end
`endif
      if (reset) begin
         m_gnt = -1;
         m_ptr = 0;
         m_ok  = 1'b1;
`ifdef NOC_ARB_HOLD_TIMEOUT_EN
         m_cnt = 0;
         m_to  = 1'b0;
`endif
      end else if (m_gnt < 0) begin
         m_gnt = first_from(m_ptr);
`ifdef NOC_ARB_HOLD_TIMEOUT_EN
         m_cnt = 0;
`endif
      end else if (rel) begin
         m_ptr = (m_gnt + 1) % N;
         m_gnt = first_from(m_ptr);
`ifdef NOC_ARB_HOLD_TIMEOUT_EN
         m_cnt = 0;
`endif
      end else begin
`ifdef NOC_ARB_HOLD_TIMEOUT_EN
         m_cnt++;
`endif
      end
   end

   // Compare DUT against the model and the output invariants every cycle
   always @(negedge clk) begin
      if (m_ok) begin
         logic [N-1:0] exp_g;
         exp_g = '0;
         if (m_gnt >= 0) exp_g[m_gnt] = 1'b1;
         check("grant_o", 32'(grant), 32'(exp_g));
         check("grant_valid_o", 32'(grant_valid), 32'(m_gnt >= 0));
         check("grant_idx_o", 32'(grant_idx), (m_gnt >= 0) ? 32'(m_gnt) : 32'd0);
         check("rr_ptr_o", 32'(rr_ptr), 32'(m_ptr));
         check("onehot_or_zero", 32'($onehot0(grant)), 32'd1);
         check("valid_eq_or", 32'(grant_valid), 32'(|grant));
`ifdef NOC_ARB_HOLD_TIMEOUT_EN
         check("hold_timeout_o", 32'(hold_timeout), 32'(m_to));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int j, input logic [AW-1:0] a);
      addr[j*AW +: AW] = a;
   endtask

   initial begin
      reset      = 1'b1;
      addr       = '0;
      valid      = '0;
      release_in = 1'b0;
      tick();
      tick();
      check("reset_grant", 32'(grant), 32'd0);
      check("reset_ptr", 32'(rr_ptr), 32'd0);
      reset = 1'b0;

      // Requesters 1 and 3 contend, ptr=0
      valid = 4'b1010;
      tick();
      check("t1_grant", 32'(grant), 32'h2);
      check("t1_idx", 32'(grant_idx), 32'd1);
      release_in = 1'b1;
      tick();
      check("t1_handoff_grant", 32'(grant), 32'h8);
      check("t1_handoff_idx", 32'(grant_idx), 32'd3);
      check("t1_handoff_ptr", 32'(rr_ptr), 32'd2);
      valid = 4'b0000;
      tick();
      check("t1_idle_valid", 32'(grant_valid), 32'd0);
      check("t1_idle_ptr", 32'(rr_ptr), 32'd0);
      release_in = 1'b0;

      // All four desire, release every cycle: 0,1,2,3,0,1,2,3,0
      valid = 4'b1111;
      tick();
      check("t2_first", 32'(grant_idx), 32'd0);
      release_in = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("t2_seq", 32'(grant_idx), 32'((k + 1) % 4));
      end
      check("t2_ptr_wrapped", 32'(rr_ptr), 32'd0);
      valid = 4'b0000;
      tick();
      release_in = 1'b0;
      check("t2_idle_ptr", 32'(rr_ptr), 32'd1);

      // Requester 2 points elsewhere; release in IDLE is ignored
      valid = 4'b0100;
      set_addr(2, 3'd1);
      release_in = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      check("t3_never_granted", 32'(grant_valid), 32'd0);
      check("t3_ptr_unmoved", 32'(rr_ptr), 32'd1);
      release_in = 1'b0;
      set_addr(2, 3'd0);

      // Wormhole lock: granted requester 0 drops valid, requester 1 waits
      valid = 4'b0001;
      tick();
      check("t4_grant0", 32'(grant), 32'h1);
      valid = 4'b0010;
      for (int k = 0; k < 3; k++) tick();
      check("t4_held", 32'(grant), 32'h1);
      release_in = 1'b1;
      tick();
      check("t4_moved", 32'(grant), 32'h2);
      check("t4_ptr", 32'(rr_ptr), 32'd1);
      // Only the granted requester desires at release: re-granted, ptr advances
      tick();
      check("t4_regrant", 32'(grant), 32'h2);
      check("t4_regrant_ptr", 32'(rr_ptr), 32'd2);

      // Reach idx=2, then reset mid-packet with release asserted
      valid = 4'b0100;
      tick();
      release_in = 1'b0;
      check("t5_idx2", 32'(grant_idx), 32'd2);
      reset      = 1'b1;
      release_in = 1'b1;
      tick();
      check("t5_rst_grant", 32'(grant), 32'd0);
      check("t5_rst_valid", 32'(grant_valid), 32'd0);
      check("t5_rst_idx", 32'(grant_idx), 32'd0);
      check("t5_rst_ptr", 32'(rr_ptr), 32'd0);
      reset      = 1'b0;
      release_in = 1'b0;
      valid      = 4'b0000;
      tick();

      // Long hold without release, requester 1 also desiring
      valid = 4'b0011;
      tick();
      check("t6_grant0", 32'(grant), 32'h1);
`ifdef NOC_ARB_HOLD_TIMEOUT_EN
      for (int k = 0; k < 15; k++) tick();
      check("t6_still0", 32'(grant), 32'h1);
      tick();
      check("t6_timeout_grant", 32'(grant), 32'h2);
      check("t6_timeout_pulse", 32'(hold_timeout), 32'd1);
`else
      for (int k = 0; k < 100; k++) tick();
      check("t6_held100", 32'(grant), 32'h1);
      check("t6_ptr", 32'(rr_ptr), 32'd0);
`endif
      valid = 4'b0000;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_noc_rr_port_arbiter
